// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave to AXI4-Stream bridge.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_slave_state_t;

  localparam int SPI_SYNC_STAGES    = 2;
  localparam int SPI_MIN_OVERSAMPLE = 8;

endpackage

// File: rtl/axi4s_if.sv
// AXI4-Stream bundle. A beat transfers on any clk edge where tvalid && tready;
// the master holds tdata/tuser/tlast/tkeep stable and tvalid high until that edge.
interface axi4s_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [0:0]              tuser;

  modport master (output tdata, tvalid, tlast, tkeep, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, tuser, output tready);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with one extra register
// so rising/falling edges of the synchronized level can be detected.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SPI_SYNC_STAGES-1:0] sync_q;
  logic                       prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SPI_SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SPI_SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SPI_SYNC_STAGES-1];
    end
  end

  assign sync = sync_q[SPI_SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/spi_slave_to_axis.sv
// SPI mode-0 slave, oversampled in the clk domain, bridging to AXI4-Stream.
// Optional SPI_SLAVE_OVERRUN_CNT_EN adds a saturating overrun_cnt output.
module spi_slave_to_axis
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TX_FILL    = {DATA_WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  axi4s_if.master          m_axis,
  axi4s_if.slave           s_axis,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  input  logic             spi_ss,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             overrun,
  output logic             underrun,
  output logic             frame_err,
`ifdef SPI_SLAVE_OVERRUN_CNT_EN
  output logic [15:0]      overrun_cnt,
`endif
  output spi_slave_state_t fsm_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic [SPI_SYNC_STAGES-1:0] mosi_q;
  logic mosi_sync;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk (clk), .rst (rst), .din (spi_sclk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk (clk), .rst (rst), .din (spi_ss),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_q <= '0;
    else     mosi_q <= {mosi_q[SPI_SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_sync = mosi_q[SPI_SYNC_STAGES-1];

  spi_slave_state_t      state;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  first;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  m_tvalid_q;
  logic                  m_tuser_q;
  logic [1:0]            settle_cnt;
  logic                  armed;

  // After reset, a frame may only start once SS has been seen high with the
  // synchronizer flushed, so a select held low through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      first      <= 1'b0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      frame_err  <= 1'b0;
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;

      if (settle_cnt != 2'd3) settle_cnt <= settle_cnt + 2'd1;
      else if (ss_sync)       armed      <= 1'b1;

      if (m_tvalid_q && m_axis.tready) m_tvalid_q <= 1'b0;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (armed && ss_fall) begin
            state <= LOAD;
            first <= 1'b1;
          end
        end
        LOAD: begin
          if (s_axis.tvalid) begin
            tx_sr <= s_axis.tdata;
          end else begin
            tx_sr    <= TX_FILL;
            underrun <= 1'b1;
          end
          state <= SHIFT;
        end
        SHIFT: begin
          if (sclk_rise) begin
            rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_sync};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= LOAD;
              if (!m_tvalid_q || m_axis.tready) begin
                m_tdata_q  <= {rx_sr[DATA_WIDTH-2:0], mosi_sync};
                m_tvalid_q <= 1'b1;
                m_tuser_q  <= first;
                first      <= 1'b0;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall && bit_cnt != '0) begin
            // At bit_cnt 0 the freshly loaded MSB is already on MISO.
            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase

      if (ss_rise) begin
        state   <= IDLE;
        bit_cnt <= '0;
        if (bit_cnt != '0) frame_err <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                 overrun_cnt_q <= '0;
    else if (overrun && overrun_cnt_q != '1) overrun_cnt_q <= overrun_cnt_q + 16'd1;
  end
  assign overrun_cnt = overrun_cnt_q;
`endif

  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign m_axis.tuser  = m_tuser_q;
  assign m_axis.tlast  = 1'b0;
  assign m_axis.tkeep  = '1;
  assign s_axis.tready = (state == LOAD);

  assign spi_miso_oe = ~ss_sync;
  assign spi_miso    = ~ss_sync & tx_sr[DATA_WIDTH-1];
  assign fsm_state   = state;

  logic unused_inputs;
  assign unused_inputs = ^{s_axis.tlast, s_axis.tkeep, s_axis.tuser, sclk_sync};

endmodule

// File: tb/tb_spi_slave_to_axis.sv
// Directed bench for spi_slave_to_axis: SPI master driver, s_axis source,
// m_axis scoreboard monitor. Honors SPI_SLAVE_OVERRUN_CNT_EN when defined.
`timescale 1ns/1ps
module tb_spi_slave_to_axis;
  import spi_pkg::*;

  localparam int DW   = 8;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_ss   = 1'b1;
  logic spi_miso, spi_miso_oe, overrun, underrun, frame_err;
  spi_slave_state_t fsm_state;
`ifdef SPI_SLAVE_OVERRUN_CNT_EN
  logic [15:0] overrun_cnt;
`endif

  axi4s_if #(.DATA_WIDTH(DW)) m_axis ();
  axi4s_if #(.DATA_WIDTH(DW)) s_axis ();

  always #5 clk = ~clk;

  spi_slave_to_axis #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_axis     (m_axis),
    .s_axis     (s_axis),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_ss     (spi_ss),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .overrun    (overrun),
    .underrun   (underrun),
    .frame_err  (frame_err),
`ifdef SPI_SLAVE_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .fsm_state  (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  int n_ovr  = 0;
  int n_und  = 0;
  int n_ferr = 0;
  logic [8:0] exp_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // s_axis source: presents the head of tx_q, pops it after each handshake.
  initial begin
    logic hs;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;
    s_axis.tkeep  = '1;
    s_axis.tuser  = '0;
    forever begin
      @(negedge clk);
      hs = s_axis.tvalid && s_axis.tready;
      @(posedge clk);
      #1;
      if (hs) void'(tx_q.pop_front());
      s_axis.tvalid = (tx_q.size() != 0);
      s_axis.tdata  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    end
  end

  // Monitor: counts status pulses and scores every m_axis beat.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      n_ovr  += int'(overrun);
      n_und  += int'(underrun);
      n_ferr += int'(frame_err);
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got tuser=%0d tdata=0x%02h, expected none",
                   m_axis.tuser, m_axis.tdata);
        end else begin
          e = exp_q.pop_front();
          check("m_axis_word", {23'd0, m_axis.tuser, m_axis.tdata}, {23'd0, e});
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      clk_wait(HALF);
      spi_sclk  = 1'b1;
      mi[7-i]   = spi_miso;
      clk_wait(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic ss_low();
    spi_ss = 1'b0;
    clk_wait(HALF);
  endtask

  task automatic ss_high();
    clk_wait(HALF);
    spi_ss = 1'b1;
    clk_wait(8);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [7:0] mi;
    int u0, o0, f0;
    m_axis.tready = 1'b1;

    // Reset state
    clk_wait(4);
    check("rst_tvalid",  m_axis.tvalid, 0);
    check("rst_tdata",   m_axis.tdata, 0);
    check("rst_tuser",   m_axis.tuser, 0);
    check("rst_tlast",   m_axis.tlast, 0);
    check("rst_tkeep",   m_axis.tkeep, 1);
    check("rst_tready",  s_axis.tready, 0);
    check("rst_miso",    {spi_miso, spi_miso_oe}, 0);
    check("rst_pulses",  {overrun, underrun, frame_err}, 0);
    check("rst_state",   {30'd0, fsm_state}, {30'd0, IDLE});
    rst = 1'b0;
    clk_wait(6);
`ifdef SPI_SLAVE_OVERRUN_CNT_EN
    check("rst_ovr_cnt", overrun_cnt, 0);
`endif

    // Two-word frame with preloaded TX data
    tx_q.push_back(8'h3C);
    tx_q.push_back(8'h5A);
    clk_wait(2);
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b0, 8'h0F});
    ss_low();
    spi_bits(8'hA5, 8, mi);
    check("miso_w0", mi, 8'h3C);
    check("miso_oe_sel", spi_miso_oe, 1);
    spi_bits(8'h0F, 8, mi);
    check("miso_w1", mi, 8'h5A);
    ss_high();
    check("miso_oe_desel", spi_miso_oe, 0);
    wait_drain();

    // Empty s_axis: fill word on MISO
    u0 = n_und;
    exp_q.push_back({1'b1, 8'h81});
    ss_low();
    clk_wait(2);
    check("underrun_cnt", n_und - u0, 1);
    spi_bits(8'h81, 8, mi);
    check("miso_fill", mi, 8'hFF);
    ss_high();
    wait_drain();

    // Overrun while m_axis is stalled
    m_axis.tready = 1'b0;
    o0 = n_ovr;
    exp_q.push_back({1'b1, 8'h11});
    ss_low();
    spi_bits(8'h11, 8, mi);
    spi_bits(8'h22, 8, mi);
    spi_bits(8'h33, 8, mi);
    ss_high();
    check("ovr_tvalid", m_axis.tvalid, 1);
    check("ovr_tdata",  m_axis.tdata, 8'h11);
    check("overrun_cnt_pulses", n_ovr - o0, 2);
`ifdef SPI_SLAVE_OVERRUN_CNT_EN
    check("overrun_cnt_port", overrun_cnt, 2);
`endif
    m_axis.tready = 1'b1;
    wait_drain();

    // SS deasserted after 5 bits
    f0 = n_ferr;
    ss_low();
    spi_bits(8'hC3, 5, mi);
    ss_high();
    check("frame_err_cnt", n_ferr - f0, 1);
    check("frame_err_noword", m_axis.tvalid, 0);
    exp_q.push_back({1'b1, 8'h7E});
    ss_low();
    spi_bits(8'h7E, 8, mi);
    ss_high();
    wait_drain();

    // Reset mid-word with SS held low
    ss_low();
    spi_bits(8'hF0, 3, mi);
    rst = 1'b1;
    clk_wait(3);
    check("midrst_state", {30'd0, fsm_state}, {30'd0, IDLE});
    rst = 1'b0;
    clk_wait(6);
    spi_bits(8'h55, 8, mi);
    clk_wait(10);
    check("midrst_noword", m_axis.tvalid, 0);
    check("midrst_idle", {30'd0, fsm_state}, {30'd0, IDLE});
    ss_high();
    exp_q.push_back({1'b1, 8'h96});
    ss_low();
    spi_bits(8'h96, 8, mi);
    ss_high();
    wait_drain();

    // Back-to-back words at clk/8 with s_axis continuously valid
    tx_q.push_back(8'hC5);
    tx_q.push_back(8'h3A);
    tx_q.push_back(8'h99);
    clk_wait(2);
    u0 = n_und;
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b0, 8'hFF});
    ss_low();
    spi_bits(8'h00, 8, mi);
    check("b2b_miso0", mi, 8'hC5);
    spi_bits(8'hFF, 8, mi);
    check("b2b_miso1", mi, 8'h3A);
    ss_high();
    check("b2b_no_underrun", n_und - u0, 0);
    wait_drain();

    clk_wait(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
